wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port after the write-back stage. Merges in-order pipeline

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_port_arbiter_if.sv | 32 +++
 rtl/wb_arb_fifo.sv | 78 +++++++
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter: FSM states, grant sources and the
// register-write entry carried through the unit-result FIFO.
package wb_arb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic [1:0] {RUN, DRAIN, HALT} arb_state_e;

   typedef enum logic [1:0] {G_NONE, G_PIPE, G_FIFO} grant_src_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Pipeline, multi-cycle-unit and register-file signals of the write-back port arbiter.
// slave = arbiter side, master = the surrounding core (or a bench).
interface wb_port_arbiter_if;
   import wb_arb_pkg::*;

   logic              pipe_wb_en;
   logic [ADDR_W-1:0] pipe_wb_addr;
   logic [DATA_W-1:0] pipe_wb_data;
   logic              pipe_brk;
   logic              pipe_stall;
   logic              mc_valid;
   logic [ADDR_W-1:0] mc_addr;
   logic [DATA_W-1:0] mc_data;
   logic              mc_ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              halted;

   modport slave (
      input  pipe_wb_en, pipe_wb_addr, pipe_wb_data, pipe_brk,
      input  mc_valid, mc_addr, mc_data,
      output pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, halted
   );

   modport master (
      output pipe_wb_en, pipe_wb_addr, pipe_wb_data, pipe_brk,
      output mc_valid, mc_addr, mc_data,
      input  pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, halted
   );

endinterface

// File: rtl/wb_arb_fifo.sv
// Unit-result FIFO: circular buffer with occupancy count, head output and a per-entry
// address-match vector so the arbiter can detect write-order hazards against the pipeline.
module wb_arb_fifo
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  wb_entry_t         push_entry,
   input  logic              pop,
   input  logic [ADDR_W-1:0] cmp_addr,
   output wb_entry_t         head,
   output logic              full,
   output logic              empty,
   output logic [DEPTH-1:0]  addr_match
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W-1:0] offset;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // NOTE: every variable gets its default before any branch, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      addr_match = '0;
      offset     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - rd_ptr_q;
         if (({1'b0, offset} < count_q) && (mem_q[i].addr == cmp_addr))
            addr_match[i] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges pipeline and unit write-backs, prevents starvation,
// keeps order on address hazards and sequences the BREAK drain/halt. Optional stats: WB_ARB_STATS_EN.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_STATS_EN
   ,
   output logic [31:0]        stat_pipe_wr,
   output logic [31:0]        stat_mc_wr,
   output logic [31:0]        stat_stall_cyc
`endif
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   arb_state_e          state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

   grant_src_e          grant;
   wb_entry_t           fifo_head, pipe_entry, win;
   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [FIFO_DEPTH-1:0] addr_match;
   logic                hazard, starved, pipe_stall, mc_ready;

   wb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_entry ('{addr: bus.mc_addr, data: bus.mc_data}),
      .pop        (fifo_pop),
      .cmp_addr   (bus.pipe_wb_addr),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .addr_match (addr_match)
   );

   always_comb begin
      grant      = G_NONE;
      pipe_stall = 1'b0;
      mc_ready   = 1'b0;
      state_d    = state_q;
      starve_d   = starve_q;
      pipe_entry = '{addr: bus.pipe_wb_addr, data: bus.pipe_wb_data};
      hazard     = bus.pipe_wb_en && (|addr_match);
      starved    = !fifo_empty && (starve_q == LIMIT);

      if (state_q == HALT) begin
         pipe_stall = 1'b1;
      end else begin
         mc_ready = !fifo_full;
         if (!fifo_empty && (starved || hazard || state_q == DRAIN)) grant = G_FIFO;
         else if (state_q == RUN && bus.pipe_wb_en)                grant = G_PIPE;
         else if (!fifo_empty)                                     grant = G_FIFO;

         // In RUN the head can only beat a live pipeline request via starvation or hazard.
         pipe_stall = (state_q == DRAIN) || (bus.pipe_wb_en && grant == G_FIFO);

         if (fifo_empty || grant == G_FIFO) starve_d = '0;
         else if (starve_q != LIMIT)        starve_d = starve_q + STARVE_W'(1);

         if (state_q == RUN && bus.pipe_brk && !pipe_stall)          state_d = DRAIN;
         else if (state_q == DRAIN && fifo_empty && !bus.mc_valid)   state_d = HALT;
      end

      win        = (grant == G_FIFO) ? fifo_head : pipe_entry;
      rf_we_d    = (grant != G_NONE) && (win.addr != '0);
      rf_waddr_d = (grant != G_NONE) ? win.addr : rf_waddr_q;
      rf_wdata_d = (grant != G_NONE) ? win.data : rf_wdata_q;
   end

   assign fifo_push = bus.mc_valid && mc_ready;
   assign fifo_pop  = (grant == G_FIFO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         starve_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.pipe_stall = pipe_stall;
   assign bus.mc_ready   = mc_ready;
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_waddr   = rf_waddr_q;
   assign bus.rf_wdata   = rf_wdata_q;
   assign bus.halted     = (state_q == HALT);

`ifdef WB_ARB_STATS_EN
   grant_src_e  src_q;
   logic [31:0] stat_pipe_wr_q, stat_pipe_wr_d;
   logic [31:0] stat_mc_wr_q, stat_mc_wr_d;
   logic [31:0] stat_stall_cyc_q, stat_stall_cyc_d;

   // Source is registered alongside rf_we so counts track writes actually issued.
   always_comb begin
      stat_pipe_wr_d   = stat_pipe_wr_q;
      stat_mc_wr_d     = stat_mc_wr_q;
      stat_stall_cyc_d = stat_stall_cyc_q;
      if (rf_we_q && src_q == G_PIPE && stat_pipe_wr_q != '1)
         stat_pipe_wr_d = stat_pipe_wr_q + 32'd1;
      if (rf_we_q && src_q == G_FIFO && stat_mc_wr_q != '1)
         stat_mc_wr_d = stat_mc_wr_q + 32'd1;
      if (pipe_stall && state_q != HALT && stat_stall_cyc_q != '1)
         stat_stall_cyc_d = stat_stall_cyc_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q            <= G_NONE;
         stat_pipe_wr_q   <= '0;
         stat_mc_wr_q     <= '0;
         stat_stall_cyc_q <= '0;
      end else begin
         src_q            <= grant;
         stat_pipe_wr_q   <= stat_pipe_wr_d;
         stat_mc_wr_q     <= stat_mc_wr_d;
         stat_stall_cyc_q <= stat_stall_cyc_d;
      end
   end

   assign stat_pipe_wr   = stat_pipe_wr_q;
   assign stat_mc_wr     = stat_mc_wr_q;
   assign stat_stall_cyc = stat_stall_cyc_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_port_arbiter_if bus ();

   wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: FIFO as a queue, starve count, mode 0=run 1=drain 2=halt.
   wb_entry_t   m_q[$];
   int          m_starve;
   int          m_mode;
   logic        exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   logic        m_stall_last;

   // Stimulus: pending unit results (held until accepted) and the current pipeline request.
   wb_entry_t   mc_q[$];
   logic        p_en, p_brk;
   logic [4:0]  p_addr;
   logic [31:0] p_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle; entered and left just after a falling edge.
   task automatic cyc();
      bit        g_fifo, g_pipe, ready, stall, hazard, mv;
      int        pre_size;
      wb_entry_t w;
      mv               = (mc_q.size() > 0);
      bus.pipe_wb_en   = p_en;
      bus.pipe_wb_addr = p_addr;
      bus.pipe_wb_data = p_data;
      bus.pipe_brk     = p_brk;
      bus.mc_valid     = mv;
      if (mv) begin
         bus.mc_addr = mc_q[0].addr;
         bus.mc_data = mc_q[0].data;
      end
      #1;
      pre_size = m_q.size();
      hazard   = 0;
      foreach (m_q[i]) if (p_en && m_q[i].addr == p_addr) hazard = 1;
      g_fifo = 0;
      g_pipe = 0;
      stall  = 1;
      ready  = 0;
      if (m_mode != 2) begin
         ready = (pre_size < DEPTH);
         if (pre_size > 0 && (m_starve >= LIMIT || hazard || m_mode == 1)) g_fifo = 1;
         else if (m_mode == 0 && p_en) g_pipe = 1;
         else if (pre_size > 0) g_fifo = 1;
         stall = (m_mode != 0) || (p_en && g_fifo);
      end
      check("rf_we", bus.rf_we, exp_we);
      if (exp_we) begin
         check("rf_waddr", bus.rf_waddr, exp_addr);
         check("rf_wdata", bus.rf_wdata, exp_data);
      end
      check("halted", bus.halted, m_mode == 2);
      check("pipe_stall", bus.pipe_stall, stall);
      check("mc_ready", bus.mc_ready, ready);

      w = '{addr: p_addr, data: p_data};
      if (g_fifo) w = m_q.pop_front();
      exp_we = (g_fifo || g_pipe) && (w.addr != 0);
      if (g_fifo || g_pipe) begin
         exp_addr = w.addr;
         exp_data = w.data;
      end
      if (mv && ready) m_q.push_back(mc_q.pop_front());
      if (pre_size == 0 || g_fifo) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (m_mode == 0 && p_brk && !stall) m_mode = 1;
      else if (m_mode == 1 && pre_size == 0 && !mv) m_mode = 2;
      m_stall_last = stall;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      p_en  = 0;
      p_brk = 0;
      repeat (n) cyc();
   endtask

   // Present a pipeline write and hold it until it is not stalled.
   task automatic pipe_go(input logic [4:0] a, input logic [31:0] d, input logic brk);
      int n = 0;
      p_en   = 1;
      p_addr = a;
      p_data = d;
      p_brk  = brk;
      do begin
         cyc();
         n++;
      end while (m_stall_last && n < 16);
      check("pipe_accept_timeout", n >= 16, 1'b0);
      p_en  = 0;
      p_brk = 0;
   endtask

   task automatic mc_push(input logic [4:0] a, input logic [31:0] d);
      mc_q.push_back('{addr: a, data: d});
   endtask

   // Asynchronous reset asserted at an arbitrary point; outputs must clear without a clock.
   task automatic apply_reset();
      p_en = 0; p_brk = 0; p_addr = 0; p_data = 0;
      bus.pipe_wb_en = 0; bus.pipe_brk = 0; bus.mc_valid = 0;
      bus.pipe_wb_addr = 0; bus.pipe_wb_data = 0; bus.mc_addr = 0; bus.mc_data = 0;
      mc_q.delete();
      rst = 1'b0;
      #1;
      check("rst_rf_we", bus.rf_we, 1'b0);
      check("rst_rf_waddr", bus.rf_waddr, 5'd0);
      check("rst_rf_wdata", bus.rf_wdata, 32'd0);
      check("rst_halted", bus.halted, 1'b0);
      check("rst_pipe_stall", bus.pipe_stall, 1'b0);
      check("rst_mc_ready", bus.mc_ready, 1'b1);
      m_q.delete();
      m_starve = 0;
      m_mode   = 0;
      exp_we   = 0;
      exp_addr = 0;
      exp_data = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2;
      apply_reset();

      // 1: back-to-back pipeline writes, no unit traffic.
      pipe_go(5'd3, 32'h11, 1'b0);
      pipe_go(5'd4, 32'h22, 1'b0);
      idle(2);

      // 2: FIFO holds r5=AA, pipeline then writes r5=BB -> hazard stall, order kept.
      mc_push(5'd5, 32'hAA);
      pipe_go(5'd1, 32'h01, 1'b0);
      pipe_go(5'd5, 32'hBB, 1'b0);
      idle(2);

      // 3: FIFO holds r7 while the pipeline streams writes -> starvation stall.
      mc_push(5'd7, 32'h77);
      for (int i = 8; i < 14; i++) pipe_go(5'(i), 32'h100 + 32'(i), 1'b0);
      idle(2);

      // 4: three unit results offered while the pipeline is busy.
      mc_push(5'd12, 32'hC12);
      mc_push(5'd13, 32'hC13);
      mc_push(5'd14, 32'hC14);
      for (int i = 15; i < 23; i++) pipe_go(5'(i), 32'h200 + 32'(i), 1'b0);
      idle(3);

      // 5: BREAK with its own write while r6 sits in the FIFO; unit ignored after halt.
      mc_push(5'd6, 32'h66);
      pipe_go(5'd9, 32'h99, 1'b0);
      pipe_go(5'd2, 32'h5, 1'b1);
      idle(3);
      check("t5_halted", bus.halted, 1'b1);
      mc_push(5'd10, 32'hDEAD);
      idle(3);
      check("t5_mc_ready_after_halt", bus.mc_ready, 1'b0);
      apply_reset();

      // Random traffic; small address range to provoke hazards, rare BREAKs.
      for (int c = 0; c < 600; c++) begin
         if (m_mode == 2) apply_reset();
         if (!p_en || !m_stall_last) begin
            p_en   = ($urandom_range(0, 2) != 0);
            p_addr = 5'($urandom_range(0, 7));
            p_data = $urandom;
            p_brk  = ($urandom_range(0, 79) == 0);
         end
         if (mc_q.size() < 2 && $urandom_range(0, 2) == 0)
            mc_push(5'($urandom_range(0, 7)), $urandom);
         cyc();
      end
      apply_reset();

      // 6: write to r0 is consumed silently; reset pulsed in the middle of a drain.
      mc_push(5'd6, 32'h600);
      mc_push(5'd9, 32'h900);
      pipe_go(5'd0, 32'h1234, 1'b0);
      check("t6_r0_no_we", bus.rf_we, 1'b0);
      pipe_go(5'd1, 32'h7, 1'b1);
      cyc();
      apply_reset();
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
